// File: rtl/if_fetch_pkg.sv
// Shared types for the instruction fetch stage: bus widths, fetch state
// encodings and the per-state byte address helper.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  typedef enum logic [2:0] {
    FetchS0 = 3'd0,
    FetchS1 = 3'd1,
    FetchS2 = 3'd2,
    FetchS3 = 3'd3,
    FetchS4 = 3'd4
  } fetch_st_e;

  // S4 only consumes the last byte, so it keeps pc+3 on the bus.
  function automatic logic [InstAddrBus-1:0] byte_addr(
    input logic [InstAddrBus-1:0] pc,
    input fetch_st_e              st
  );
    logic [InstAddrBus-1:0] a;
    case (st)
      FetchS0: a = pc;
      FetchS1: a = pc + 32'd1;
      FetchS2: a = pc + 32'd2;
      default: a = pc + 32'd3;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// RV32I fetch stage: owns the PC, assembles a little-endian word from four
// byte reads on the 8-bit bus and hands it to if_id under valid/stall.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a_o,
  output logic        mem_req_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [2:0]  st_o
);

  fetch_st_e         st_q, st_d;
  logic [31:0]       pc_q, pc_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       pco_q, pco_d;

  assign mem_a_o      = byte_addr(pc_q, st_q);
  assign mem_req_o    = !rst && (st_q != FetchS4);
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pco_q;
  assign st_o         = st_q;

  // Handshake: the word is taken on any cycle with valid=1 and stall_i=0;
  // valid drops on the next edge unless S4 loads a new word on that edge.
  always_comb begin
    st_d    = st_q;
    pc_d    = pc_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pco_d   = pco_q;
    if (!rdy) begin
      // Byte in flight is unreliable: restart this word from byte 0.
      st_d = FetchS0;
    end else if (br_e) begin
      pc_d    = br_addr;
      st_d    = FetchS0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && !stall_i) valid_d = 1'b0;
      case (st_q)
        FetchS0: if (!(valid_q && stall_i)) st_d = FetchS1;
        FetchS1: begin
          b0_d = mem_din;
          st_d = FetchS2;
        end
        FetchS2: begin
          b1_d = mem_din;
          st_d = FetchS3;
        end
        FetchS3: begin
          b2_d = mem_din;
          st_d = FetchS4;
        end
        FetchS4: begin
          inst_d  = {mem_din, b2_q, b1_q, b0_q};
          pco_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          st_d    = FetchS0;
        end
        default: st_d = FetchS0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= FetchS0;
      pc_q    <= RESET_PC;
      b0_q    <= 8'h0;
      b1_q    <= 8'h0;
      b2_q    <= 8'h0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0;
      pco_q   <= 32'h0;
    end else begin
      st_q    <= st_d;
      pc_q    <= pc_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pco_q   <= pco_d;
    end
  end

endmodule
